// File: rtl/matrix_loader_pkg.sv
// Shared types and helpers for the 4x4 determinant/inverse datapath.
//   float_t       : IEEE-754 single-precision word
//   MAT_N/ELEMS   : matrix order and element count
//   FP_EXP_INF    : all-ones exponent marking Inf/NaN
//   is_nonfinite  : true when a word is Inf or NaN
//   ldr_state_t   : loader FSM states
package matrix_pkg;

  typedef logic [31:0] float_t;

  localparam int unsigned MAT_N     = 4;
  localparam int unsigned MAT_ELEMS = MAT_N * MAT_N;

  localparam logic [7:0] FP_EXP_INF = 8'hFF;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } ldr_state_t;

  // Inf and NaN share the all-ones exponent; the mantissa is irrelevant here.
  function automatic logic is_nonfinite(input float_t f);
    return f[30:23] == FP_EXP_INF;
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Serial-to-parallel matrix loader.
// Accepts N*N words over a valid/ready stream (row-major), assembles them into
// a register bank and presents the complete matrix until the consumer takes it.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous abort of any partial or held matrix
//   in_data/in_valid  : element word stream
//   in_ready          : high while loading (decoded from state only)
//   mat_data          : assembled matrix, element index = row*N + col
//   mat_valid         : mat_data holds a complete matrix
//   mat_ready         : consumer takes the matrix this cycle
//   mat_nonfinite     : some element of the held matrix is Inf/NaN
//   count             : words accepted into the current matrix
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         mat_data [N*N],
  output logic                      mat_valid,
  input  logic                      mat_ready,
  output logic                      mat_nonfinite,
  output logic [$clog2(N*N):0]      count
);

  localparam int unsigned ELEMS = N * N;
  localparam int unsigned CNT_W = $clog2(ELEMS) + 1;

  ldr_state_t state;
  logic       accept;
  logic       last_word;

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state == LOAD);
  assign mat_valid = (state == HOLD);

  assign accept    = in_valid && (state == LOAD);
  assign last_word = (count == CNT_W'(ELEMS - 1));

  // Loader FSM, element counter and nonfinite flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD;
      count         <= '0;
      mat_nonfinite <= 1'b0;
    end else if (flush) begin
      state         <= LOAD;
      count         <= '0;
      mat_nonfinite <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            count         <= count + CNT_W'(1);
            mat_nonfinite <= mat_nonfinite | is_nonfinite(float_t'(in_data));
            if (last_word) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (mat_ready) begin
            state         <= LOAD;
            count         <= '0;
            mat_nonfinite <= 1'b0;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Register bank written by index decode; never cleared except by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ELEMS; i++) begin
        mat_data[i] <= '0;
      end
    end else if (!flush && accept) begin
      for (int unsigned i = 0; i < ELEMS; i++) begin
        if (count == CNT_W'(i)) begin
          mat_data[i] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: a driver streams matrices and queues the
// expected array and nonfinite flag; a monitor pops and compares whenever the
// loader presents a matrix, and re-checks it every cycle it is held.
module tb_matrix_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mat_data [16];
  logic        mat_valid;
  logic        mat_ready = 1'b0;
  logic        mat_nonfinite;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_vcyc = -1;

  logic [31:0]  stim [16];
  logic [511:0] exp_q [$];
  bit           nf_q [$];

  matrix_loader #(.DATA_W(32), .N(4)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mat_data(mat_data),
    .mat_valid(mat_valid),
    .mat_ready(mat_ready),
    .mat_nonfinite(mat_nonfinite),
    .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Exact IEEE-754 single encoding of a small positive integer.
  function automatic logic [31:0] float_of(input int unsigned v);
    int unsigned e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return ((127 + e) << 23) | ((v << (23 - e)) & 32'h007F_FFFF);
  endfunction

  function automatic bit ref_nonfinite();
    for (int i = 0; i < 16; i++)
      if (((stim[i] >> 23) & 32'hFF) == 32'hFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [511:0] ref_matrix();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = stim[i];
    return p;
  endfunction

  function automatic logic [31:0] rand_finite();
    logic [31:0] w = $urandom;
    if (w[30:23] == 8'hFF) w[30] = 1'b0;
    return w;
  endfunction

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) stim[i] = float_of(32'(i + 1));
  endtask

  task automatic fill_random(input int unsigned nan_pct);
    for (int i = 0; i < 16; i++) begin
      stim[i] = rand_finite();
      if ($urandom_range(99) < nan_pct) stim[i] = {stim[i][31], 8'hFF, stim[i][22:0]};
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 16; i++) stim[i] = (i % 5 == 0) ? 32'h3F80_0000 : 32'h0;
  endtask

  // ---------------- driver ----------------
  task automatic load_words(input int n, input int unsigned pv, input bit tie);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 1000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(99) < pv);
      in_data   = stim[idx];
      mat_ready = tie ? 1'b1 : 1'($urandom_range(1));
      @(negedge clk);
      chk("in_ready_load", {31'b0, in_ready}, 32'd1);
      chk("mat_valid_load", {31'b0, mat_valid}, 32'd0);
      chk("count_load", {27'b0, count}, 32'(idx));
      if (in_valid) idx++;
      guard++;
    end
    if (guard >= 1000) begin
      checks++; errors++;
      $display("FAIL load_timeout: got %0d words expected %0d", idx, n);
    end
  endtask

  task automatic hold_matrix(input int hold, input bit tie, input bit pchk);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      mat_ready = tie || (h == hold - 1);
      in_valid  = 1'($urandom_range(1));
      in_data   = $urandom;
      @(negedge clk);
      chk("in_ready_hold", {31'b0, in_ready}, 32'd0);
      chk("mat_valid_hold", {31'b0, mat_valid}, 32'd1);
      chk("count_hold", {27'b0, count}, 32'd16);
      if (h == 0) begin
        if (pchk && last_vcyc >= 0) chk("matrix_period", 32'(cyc - last_vcyc), 32'd17);
        last_vcyc = cyc;
      end
    end
  endtask

  task automatic run_matrix(input int unsigned pv, input bit tie, input int hold, input bit pchk);
    exp_q.push_back(ref_matrix());
    nf_q.push_back(ref_nonfinite());
    load_words(16, pv, tie);
    hold_matrix(hold, tie, pchk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit           have;
    logic [511:0] cur;
    bit           cur_nf;
    int           bad;
    have = 1'b0;
    cur = '0;
    cur_nf = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mat_valid) begin
        have = 1'b0;
      end else begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_matrix: mat_valid high with empty scoreboard at cycle %0d", cyc);
          end else begin
            cur    = exp_q.pop_front();
            cur_nf = nf_q.pop_front();
            have   = 1'b1;
          end
        end
        if (have) begin
          bad = -1;
          for (int i = 15; i >= 0; i--)
            if (mat_data[i] !== cur[i*32 +: 32]) bad = i;
          checks++;
          if (bad >= 0) begin
            errors++;
            $display("FAIL mat_data[%0d]: got %h expected %h at cycle %0d",
                     bad, mat_data[bad], cur[bad*32 +: 32], cyc);
          end
          chk("mat_nonfinite", {31'b0, mat_nonfinite}, {31'b0, cur_nf});
          if (mat_ready) have = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mat_valid", {31'b0, mat_valid}, 32'd0);
    chk("rst_count", {27'b0, count}, 32'd0);
    chk("rst_nonfinite", {31'b0, mat_nonfinite}, 32'd0);
    chk("rst_mat_data0", mat_data[0], 32'd0);
    chk("rst_mat_data15", mat_data[15], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1.0..16.0, continuous valid, held for 20 cycles before release.
    fill_seq();
    chk("ref_first_elem", stim[0], 32'h3F80_0000);
    chk("ref_last_elem", stim[15], 32'h4180_0000);
    run_matrix(100, 1'b0, 21, 1'b0);

    // Same stream with gapped valid.
    run_matrix(50, 1'b0, $urandom_range(4, 1), 1'b0);

    // +Inf at element 7, then an all-finite matrix.
    fill_random(0);
    stim[7] = 32'h7F80_0000;
    run_matrix(70, 1'b0, 3, 1'b0);
    fill_random(0);
    run_matrix(70, 1'b0, 2, 1'b0);

    // Flush after 9 words, then a fresh identity matrix.
    fill_random(0);
    stim[3] = 32'hFFC0_0001;
    load_words(9, 70, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("count_before_flush", {27'b0, count}, 32'd9);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("count_after_flush", {27'b0, count}, 32'd0);
    chk("in_ready_after_flush", {31'b0, in_ready}, 32'd1);
    fill_identity();
    run_matrix(60, 1'b0, 2, 1'b0);

    // mat_ready tied high, back-to-back streams.
    last_vcyc = -1;
    for (int m = 0; m < 5; m++) begin
      fill_random(3);
      run_matrix(100, 1'b1, 1, 1'b1);
    end

    // Random mix of gaps, holds and non-finite elements.
    for (int m = 0; m < 6; m++) begin
      fill_random(5);
      run_matrix($urandom_range(100, 30), 1'b0, $urandom_range(5, 1), 1'b0);
    end

    // Asynchronous reset while holding a flagged matrix.
    fill_random(0);
    stim[7] = 32'h7F80_0000;
    exp_q.push_back(ref_matrix());
    nf_q.push_back(ref_nonfinite());
    load_words(16, 80, 1'b0);
    @(posedge clk); #1;
    mat_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_mat_valid", {31'b0, mat_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mat_valid", {31'b0, mat_valid}, 32'd0);
    chk("async_rst_count", {27'b0, count}, 32'd0);
    chk("async_rst_nonfinite", {31'b0, mat_nonfinite}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("async_rst_mat_data7", mat_data[7], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Recovery after reset.
    fill_seq();
    run_matrix(90, 1'b0, 1, 1'b0);

    @(posedge clk); #1;
    mat_ready = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream stage of the 4x4 determinant/inverse datapath. Accepts a matrix as a serial stream of IEEE-754 single-precision words over a valid/ready handshake and assembles it into a register bank. Presents the complete matrix in parallel, as the 16-element unpacked array the determinant stage consumes, and holds it stable until the consumer acknowledges. Also flags matrices that contain a non-finite element.

## Interface
- `DATA_W`, default 32: element width; IEEE-754 single.
- `N`, default 4: matrix order; element count is N*N. Only 4 is verified.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous abort; discards any partial or held matrix.
- `in_data` in DATA_W: element word, row-major (index = row*N + col).
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader can accept a word this cycle.
- `mat_data` out DATA_W x N*N: unpacked array `[DATA_W-1:0] [N*N-1:0]`. Element 0 = row 0/col 0, element 15 = row 3/col 3.
- `mat_valid` out 1: `mat_data` holds a complete matrix.
- `mat_ready` in 1: consumer takes the matrix this cycle.
- `mat_nonfinite` out 1: some element of the held matrix has exponent 8'hFF (Inf/NaN). Meaningful only while `mat_valid` is high.
- `count` out log2(N*N)+1: number of words accepted into the current matrix, 0..16.

## Operation
- States: LOAD, HOLD.
- LOAD:
  - `in_ready`=1.
  - A word is accepted when `in_valid && in_ready`. It is written to bank[`count`], then `count` increments.
  - The nonfinite flag ORs in (`in_data[30:23]` == 8'hFF) on each accept.
  - The accept that brings `count` to 16 moves the state to HOLD.
- HOLD:
  - `in_ready`=0 and `mat_valid`=1.
  - The bank is frozen; `in_valid` is ignored.
  - When `mat_valid && mat_ready`: go to LOAD, clear `count` to 0, clear the nonfinite flag.
  - The bank is not cleared; stale contents remain visible but are undefined to the consumer.
- `flush` (highest priority after `rst`), in any state: next state LOAD, `count`=0, flag cleared. A word presented in the same cycle is not accepted; `in_ready` stays as its current state dictates.
- Reset values: state LOAD, `count`=0, `mat_valid`=0, `in_ready`=1 (combinational from state), `mat_nonfinite`=0, all bank entries 32'h0.
- Reset is asserted asynchronously and released synchronously by the integrator. Reset mid-load or mid-hold drops the matrix.
- Arithmetic: `count` never exceeds 16 and does not wrap. Word index 16 is unreachable because `in_ready`=0 in HOLD.
- A simultaneous `mat_ready` and `in_valid` in HOLD accepts nothing that cycle. The first word of the next matrix is accepted no earlier than the following cycle.

## Timing
- `in_ready` and `mat_valid` are decoded from registered state only; there is no combinational path from any input.
- `mat_data` and `mat_nonfinite` are direct register outputs.
- Latency: the 16th accept is at edge k; `mat_valid`=1 from edge k, so it is visible in cycle k+1.
- Throughput: 16 load cycles plus at least 1 HOLD cycle per matrix, so at best 17 cycles per matrix.
- `mat_data` is stable for every cycle `mat_valid` is high. The determinant stage is purely combinational; its result is valid, after its own combinational delay, during that window.
- `mat_ready` may be held high permanently; the loader then spends exactly one cycle in HOLD.

## Structure
- Shared package `matrix_pkg`:
  - `float_t` (logic [31:0]).
  - `MAT_N` = 4 and `MAT_ELEMS` = 16.
  - `FP_EXP_INF` = 8'hFF.
  - `function is_nonfinite(float_t)`.
  - State enum `ldr_state_t` {LOAD, HOLD}.
- Single module. The bank is a flat register array written by index decode.
- No sub-module is needed; `is_nonfinite` is a package function, reused later by the inverse output stage.

## Test plan
- Reset then stream 1.0..16.0 (32'h3F800000 … 32'h41800000) with `in_valid` held high and `mat_ready`=0. Expect:
  - `in_ready` drops in cycle 17; `mat_valid`=1.
  - `mat_data[0]`=32'h3F800000, `mat_data[15]`=32'h41800000, `mat_nonfinite`=0.
  - All values held for 20 cycles.
- Same stream with `in_valid` toggled randomly (50%): same final array; `count` increments only on handshake cycles.
- Element 7 = 32'h7F800000 (+Inf): `mat_nonfinite`=1 with `mat_valid`. After `mat_ready`, load an all-finite matrix: flag is 0.
- Assert `flush` after 9 words, then load a full fresh identity matrix: `mat_data` equals the identity (diagonal 32'h3F800000, others 0); no leftover words.
- `mat_ready` tied high with back-to-back streams: `mat_valid` is high for exactly 1 cycle per matrix; matrices arrive every 17 cycles.
- Assert `rst` asynchronously mid-HOLD, between clock edges: `mat_valid`, `count` and `mat_nonfinite` go to 0 immediately, and `in_ready`=1.
